bbj_addr_gen: RTL and testbench
===============================

Name: bbj_addr_gen

Overview:
- Address sequencer on the BlackBoxJam memory-access path; drives the 32x13 -> 44 unsigned product stage and consumes its output.
- For each started job it generates the byte address sequence addr[i] = base + i*stride for i = 0..count-1.
- Addresses are emitted on a valid/ready stream toward the AXI read/write master.
- Contains the multiplier stage as a sub-module and owns its clock-enable, so the whole pipeline stalls as one unit.

Parameters:
- IDX_W, 32, index/count width (multiplier din0).
- STRIDE_W, 13, stride width (multiplier din1).
- PROD_W, 44, product width; product truncated to PROD_W bits.
- ADDR_W, 64, output address width.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; accepted only when busy=0.
- base  in  ADDR_W  job base address, sampled on accepted start.
- stride  in  STRIDE_W  job stride in bytes, sampled on accepted start.
- count  in  IDX_W  number of addresses, sampled on accepted start.
- busy  out  1  job in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse when the last address has been accepted (or for a count=0 job).
- addr_valid  out  1  output address valid.
- addr_ready  in  1  downstream accepts.
- addr  out  ADDR_W  output address.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, addr_valid=0, addr=0, all pipeline valids=0, index=0.
- Pipeline enable: ce = !(addr_valid && !addr_ready). When ce=0, all stages hold, including the multiplier register. No bubble is inserted and no data is lost.
- Stage S0 (issue): presents din0=index, din1=stride_q to the multiplier. v0 is set while in RUN.
- Stage S1: multiplier register, prod <= zero-extend(din0)*zero-extend(din1), truncated to PROD_W. v1 <= v0 on ce.
- Stage S2 (output register): addr <= base_q + zero-extend(prod), modulo 2^ADDR_W. addr_valid <= v1 on ce.
- Latency: 2 cycles from index issue to addr_valid. With addr_ready held high, the first address appears 3 cycles after start, at 1 address/cycle.
- FSM transitions:
  - IDLE: on start, latch base/stride/count and clear index. If count==0, pulse done next cycle and stay IDLE. Otherwise go to RUN, busy=1.
  - RUN: each ce cycle, issue index and increment it. When index == count-1 is issued, go to DRAIN.
  - DRAIN: issue nothing (v0=0). When the last address is handshaken (addr_valid && addr_ready with no valid in S1), pulse done and go to IDLE.
- start while busy=1 is ignored. No queueing; parameters are unchanged.
- start in the same cycle as a done pulse is ignored. A new job is accepted only from IDLE with busy=0.
- count == 2^IDX_W-1 is legal. The index does not wrap before the last issue.
- Overflow:
  - If i*stride >= 2^PROD_W, the product truncates silently.
  - If base+offset >= 2^ADDR_W, the address wraps.
  - Neither case is flagged.
- stride == 0 is legal and yields count copies of base.
- addr stays stable while addr_valid=1 and addr_ready=0 (AXI-stream rule).
- addr_valid never drops without a handshake, except on reset.
- Reset asserted mid-job aborts immediately to the reset state. No done pulse is produced and the partial sequence is discarded.

Decomposition:
- Shared package bbj_addr_pkg holds:
  - widths IDX_W, STRIDE_W, PROD_W, ADDR_W;
  - the FSM state enum {IDLE, RUN, DRAIN};
  - the derived constant PIPE_LAT = 2.
- Sub-module bbj_mul_u32x13: registered unsigned multiplier with ports clk, ce, din0, din1, dout. It has one register stage and no reset, since its output is qualified by v1.
- The FSM, index counter, valid shift and adder stay in bbj_addr_gen.

Test Plan:
- Basic job: base=0x1000, stride=64, count=4, addr_ready=1 -> addresses 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles starting 3 cycles after start; done pulses in the cycle after the 0x10C0 handshake; busy falls with done.
- Backpressure: same job, addr_ready low for 3 cycles while 0x1040 is valid -> 0x1040 held stable; no address skipped or duplicated; total 4 handshakes; done once.
- Edge counts:
  - count=0 -> no addr_valid; done one cycle after start; busy stays 0.
  - count=1, stride=8191 -> single address equal to base.
- Wrap: base=0xFFFF_FFFF_FFFF_FFF0, stride=16, count=3 -> 0xFFFF_FFFF_FFFF_FFF0, 0x0, 0x10.
- Protocol:
  - start asserted during RUN with different base -> ignored; original sequence completes unchanged.
  - Back-to-back jobs -> second start accepted only after busy=0.
- Reset mid-job: assert ap_rst_n=0 after 2 of 8 addresses (asynchronously, mid-cycle) -> addr_valid, busy, done immediately 0. After release a new job (base=0x0, stride=4, count=2) yields exactly 0x0, 0x4.

Source files
------------

// File: rtl/bbj_addr_pkg.sv
// Shared widths, FSM state type and pipeline constants for the
// BlackBoxJam address sequencer.
package bbj_addr_pkg;

  localparam int IDX_W    = 32;
  localparam int STRIDE_W = 13;
  localparam int PROD_W   = 44;
  localparam int ADDR_W   = 64;

  // Cycles from index issue (S0) to addr_valid (S2).
  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bbj_mul_u32x13.sv
// Registered unsigned multiplier, one stage, product truncated to P_W bits.
// No reset: the output is only consumed when the matching valid is set.
module bbj_mul_u32x13
  import bbj_addr_pkg::*;
#(
  parameter int A_W = IDX_W,
  parameter int B_W = STRIDE_W,
  parameter int P_W = PROD_W
) (
  input  logic           clk,
  input  logic           ce,
  input  logic [A_W-1:0] din0,
  input  logic [B_W-1:0] din1,
  output logic [P_W-1:0] dout
);

  // Low P_W bits of the product depend only on the low P_W bits of the
  // operands, so multiplying at P_W width gives the truncated result directly.
  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;

  assign a_ext = {{(P_W-A_W){1'b0}}, din0};
  assign b_ext = {{(P_W-B_W){1'b0}}, din1};

  always_ff @(posedge clk) begin
    if (ce) begin
      dout <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/bbj_addr_gen.sv
// Address sequencer: emits base + i*stride for i = 0..count-1 on a
// valid/ready stream through a 3-stage pipeline that stalls as one unit.
module bbj_addr_gen
  import bbj_addr_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [IDX_W-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic [ADDR_W-1:0]   addr
);

  state_t state_reg, state_next;

  logic [IDX_W-1:0]    index_reg, index_next;
  logic [IDX_W-1:0]    count_reg, count_next;
  logic [STRIDE_W-1:0] stride_reg, stride_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic                done_reg, done_next;

  logic                v0;
  logic                v1_reg;
  logic                valid_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [PROD_W-1:0]   prod;
  logic                ce;
  logic                accept;

  // Only a stalled output register can stop the pipeline.
  assign ce     = !(valid_reg && !addr_ready);
  assign v0     = (state_reg == RUN);
  assign accept = start && (state_reg == IDLE) && !done_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg  <= IDLE;
      index_reg  <= '0;
      count_reg  <= '0;
      stride_reg <= '0;
      base_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      count_reg  <= count_next;
      stride_reg <= stride_next;
      base_reg   <= base_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    count_next  = count_reg;
    stride_next = stride_reg;
    base_next   = base_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          base_next   = base;
          stride_next = stride;
          count_next  = count;
          index_next  = '0;
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (ce) begin
          index_next = index_reg + 1'b1;
          if (index_reg == count_reg - 1'b1) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Nothing left in S1 means the register in S2 holds the last address.
        if (valid_reg && addr_ready && !v1_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  bbj_mul_u32x13 #(
    .A_W (IDX_W),
    .B_W (STRIDE_W),
    .P_W (PROD_W)
  ) u_mul (
    .clk  (ap_clk),
    .ce   (ce),
    .din0 (index_reg),
    .din1 (stride_reg),
    .dout (prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_reg    <= 1'b0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
    end else if (ce) begin
      v1_reg    <= v0;
      valid_reg <= v1_reg;
      if (v1_reg) begin
        addr_reg <= base_reg + {{(ADDR_W-PROD_W){1'b0}}, prod};
      end
    end
  end

  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign addr_valid = valid_reg;
  assign addr       = addr_reg;

endmodule

// File: tb/tb_bbj_addr_gen.sv
// Scoreboard bench for bbj_addr_gen: stimulus pushes hand-computed addresses,
// a negedge monitor pops and compares on every handshake.
module tb_bbj_addr_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        start;
  logic [63:0] base;
  logic [12:0] stride;
  logic [31:0] count;
  logic        busy;
  logic        done;
  logic        addr_valid;
  logic        addr_ready;
  logic [63:0] addr;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  bbj_addr_gen dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .start      (start),
    .base       (base),
    .stride     (stride),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake scoreboard plus hold-stability while stalled.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr  = '0;
  always @(negedge ap_clk) begin
    if (ap_rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {63'd0, addr_valid}, 64'd1);
        check("stall_addr_held", addr, prev_addr);
      end
      if (done) done_cnt++;
      if (addr_valid && addr_ready) begin
        hs_cnt++;
        $display("txn addr=0x%016h", addr);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_addr: got 0x%0h, expected none", addr);
        end else begin
          check("addr", addr, exp_q.pop_front());
        end
      end
      prev_stall = addr_valid && !addr_ready;
      prev_addr  = addr;
    end
  end

  task automatic start_job(input logic [63:0] b, input logic [12:0] s, input logic [31:0] c);
    @(posedge ap_clk); #1;
    start = 1'b1; base = b; stride = s; count = c;
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge of the cycle where done is high.
  task automatic wait_done(input string name, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge ap_clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, {63'd0, got}, 64'd1);
    check({name, "_busy_with_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0, d0;
    ap_rst_n   = 1'b1;
    start      = 1'b0;
    base       = '0;
    stride     = '0;
    count      = '0;
    addr_ready = 1'b1;
    #1 ap_rst_n = 1'b0;
    #11;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, addr_valid}, 64'd0);
    check("rst_addr", addr, 64'd0);
    #10 ap_rst_n = 1'b1;

    // Basic job with cycle-exact latency and done timing.
    exp_q.push_back(64'h1000); exp_q.push_back(64'h1040);
    exp_q.push_back(64'h1080); exp_q.push_back(64'h10C0);
    start_job(64'h1000, 13'd64, 32'd4);
    @(negedge ap_clk);
    check("basic_busy", {63'd0, busy}, 64'd1);
    check("basic_lat1_valid", {63'd0, addr_valid}, 64'd0);
    @(negedge ap_clk);
    check("basic_lat2_valid", {63'd0, addr_valid}, 64'd0);
    @(negedge ap_clk);
    check("basic_lat3_valid", {63'd0, addr_valid}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      check("basic_stream_valid", {63'd0, addr_valid}, 64'd1);
      check("basic_early_done", {63'd0, done}, 64'd0);
    end
    @(negedge ap_clk);
    check("basic_done", {63'd0, done}, 64'd1);
    check("basic_busy_fall", {63'd0, busy}, 64'd0);
    #1;
    check("basic_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure while 0x1040 is presented.
    h0 = hs_cnt; d0 = done_cnt;
    exp_q.push_back(64'h1000); exp_q.push_back(64'h1040);
    exp_q.push_back(64'h1080); exp_q.push_back(64'h10C0);
    start_job(64'h1000, 13'd64, 32'd4);
    repeat (3) @(posedge ap_clk);
    #1 addr_ready = 1'b0;
    @(negedge ap_clk);
    check("bp_held_addr", addr, 64'h1040);
    repeat (3) @(posedge ap_clk);
    #1 addr_ready = 1'b1;
    wait_done("bp", 50);
    #1;
    check("bp_handshakes", 64'(hs_cnt - h0), 64'd4);
    check("bp_done_count", 64'(done_cnt - d0), 64'd1);

    // count = 0: done only, no addresses, never busy.
    h0 = hs_cnt;
    start_job(64'h4000, 13'd16, 32'd0);
    @(negedge ap_clk);
    check("cnt0_done", {63'd0, done}, 64'd1);
    check("cnt0_busy", {63'd0, busy}, 64'd0);
    check("cnt0_valid", {63'd0, addr_valid}, 64'd0);
    @(negedge ap_clk);
    check("cnt0_done_pulse", {63'd0, done}, 64'd0);
    check("cnt0_handshakes", 64'(hs_cnt - h0), 64'd0);

    // count = 1 with maximum stride yields just the base.
    exp_q.push_back(64'hABCD_0000);
    start_job(64'hABCD_0000, 13'd8191, 32'd1);
    wait_done("cnt1", 50);

    // Address wrap modulo 2^64.
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h10);
    start_job(64'hFFFF_FFFF_FFFF_FFF0, 13'd16, 32'd3);
    wait_done("wrap", 50);

    // start during RUN is ignored.
    exp_q.push_back(64'h2000); exp_q.push_back(64'h2008);
    exp_q.push_back(64'h2010); exp_q.push_back(64'h2018);
    start_job(64'h2000, 13'd8, 32'd4);
    start = 1'b1; base = 64'h9000; stride = 13'd1; count = 32'd5;
    @(posedge ap_clk); #1 start = 1'b0;
    @(negedge ap_clk);
    check("ignore_busy", {63'd0, busy}, 64'd1);
    wait_done("ignore", 50);

    // Back-to-back: start in the done cycle is dropped, next start accepted.
    exp_q.push_back(64'h3000); exp_q.push_back(64'h3100);
    start_job(64'h3000, 13'h100, 32'd2);
    wait_done("b2b_a", 50);
    start = 1'b1; base = 64'h7000; stride = 13'd1; count = 32'd3;
    @(posedge ap_clk); #1 start = 1'b0;
    @(negedge ap_clk);
    check("b2b_done_cycle_start_busy", {63'd0, busy}, 64'd0);
    check("b2b_done_cycle_start_done", {63'd0, done}, 64'd0);
    exp_q.push_back(64'h7000); exp_q.push_back(64'h7001); exp_q.push_back(64'h7002);
    start_job(64'h7000, 13'd1, 32'd3);
    wait_done("b2b_b", 50);

    // Reset mid-job after two handshakes.
    h0 = hs_cnt;
    exp_q.push_back(64'h5000); exp_q.push_back(64'h5004);
    start_job(64'h5000, 13'd4, 32'd8);
    for (int k = 0; k < 50; k++) begin
      @(negedge ap_clk); #1;
      if (hs_cnt - h0 >= 2) break;
    end
    check("rstmid_handshakes", 64'(hs_cnt - h0), 64'd2);
    @(posedge ap_clk); #2 ap_rst_n = 1'b0;
    #1;
    check("rstmid_valid", {63'd0, addr_valid}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(64'h0); exp_q.push_back(64'h4);
    start_job(64'h0, 13'd4, 32'd2);
    wait_done("post_rst", 50);
    #1;
    check("post_rst_done_count", 64'(done_cnt - d0), 64'd1);

    repeat (3) @(negedge ap_clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
